// File: rtl/testdrive_axi4_read_sequencer.sv
// Splits linear read commands into 4 KB-safe AXI4 INCR bursts (one outstanding)
// and streams the returned beats downstream with end-of-command marking.
module testdrive_axi4_read_sequencer #(
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_ARID            = 0,
  parameter int C_MAX_BURST       = 16,
  parameter int C_BEATS_WIDTH     = 16
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [C_ADDR_WIDTH-1:0]      CMD_ADDR,
  input  logic [C_BEATS_WIDTH-1:0]     CMD_BEATS,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR,
  output logic [C_THREAD_ID_WIDTH-1:0] ARID,
  output logic [C_ADDR_WIDTH-1:0]      ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic                         ARLOCK,
  output logic [3:0]                   ARCACHE,
  output logic [2:0]                   ARPROT,
  output logic [3:0]                   ARREGION,
  output logic [3:0]                   ARQOS,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0] RID,
  input  logic [C_DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY,
  output logic [C_DATA_WIDTH-1:0]      DOUT_DATA,
  output logic                         DOUT_VALID,
  output logic                         DOUT_LAST,
  input  logic                         DOUT_READY
);

  localparam int BPB_LOG = $clog2(C_DATA_WIDTH / 8);
  localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK = ~C_ADDR_WIDTH'((1 << BPB_LOG) - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state, state_nxt;
  logic [C_ADDR_WIDTH-1:0]  cur_addr;
  logic [C_BEATS_WIDTH-1:0] remain;
  logic [8:0]               blen;
  logic [8:0]               bcnt;
  logic                     err;
  logic                     done;

  logic                     r_hs;
  logic                     burst_end;
  logic                     bad_beat;
  logic [C_ADDR_WIDTH-1:0]  cmd_addr_al;
  logic [C_ADDR_WIDTH-1:0]  addr_inc;
  logic [C_BEATS_WIDTH-1:0] remain_dec;

  // Burst length limited by beats left, the configured cap and the room to the next 4 KB page.
  function automatic logic [8:0] burst_len(input logic [11:0] offs,
                                           input logic [C_BEATS_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [31:0] len;
    room = (13'd4096 - {1'b0, offs}) >> BPB_LOG;
    len  = 32'(rem);
    if (len > 32'(C_MAX_BURST)) len = 32'(C_MAX_BURST);
    if (len > 32'(room))        len = 32'(room);
    return len[8:0];
  endfunction

  assign cmd_addr_al = CMD_ADDR & ALIGN_MASK;
  assign addr_inc    = cur_addr + (C_ADDR_WIDTH'(blen) << BPB_LOG);
  assign remain_dec  = remain - C_BEATS_WIDTH'(1);
  assign r_hs        = (state == DATA) && RVALID && DOUT_READY;
  assign burst_end   = r_hs && (bcnt == blen - 9'd1);
  assign bad_beat    = (RRESP != 2'b00) || (RID != C_THREAD_ID_WIDTH'(C_ARID)) ||
                       (RLAST != (bcnt == blen - 9'd1));

  assign CMD_READY  = (state == IDLE);
  assign BUSY       = (state != IDLE);
  assign DONE       = done;
  assign ERR        = err;
  assign ARVALID    = (state == ADDR);
  assign ARID       = C_THREAD_ID_WIDTH'(C_ARID);
  assign ARADDR     = cur_addr;
  assign ARLEN      = 8'(blen - 9'd1);
  assign ARSIZE     = 3'(BPB_LOG);
  assign ARBURST    = 2'b01;
  assign ARLOCK     = 1'b0;
  assign ARCACHE    = 4'b0011;
  assign ARPROT     = 3'b000;
  assign ARREGION   = 4'b0000;
  assign ARQOS      = 4'b0000;
  assign RREADY     = (state == DATA) && DOUT_READY;
  assign DOUT_VALID = (state == DATA) && RVALID;
  assign DOUT_DATA  = RDATA;
  assign DOUT_LAST  = DOUT_VALID && (remain == C_BEATS_WIDTH'(1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CMD_VALID && (CMD_BEATS != '0)) state_nxt = ADDR;
      ADDR:    if (ARREADY) state_nxt = DATA;
      DATA:    if (burst_end) state_nxt = (remain_dec != '0) ? ADDR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_addr <= '0;
      remain   <= '0;
      blen     <= 9'd1;
      bcnt     <= 9'd0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            cur_addr <= cmd_addr_al;
            remain   <= CMD_BEATS;
            err      <= 1'b0;
            if (CMD_BEATS == '0) done <= 1'b1;
            else                 blen <= burst_len(cmd_addr_al[11:0], CMD_BEATS);
          end
        end
        ADDR: if (ARREADY) bcnt <= 9'd0;
        DATA: begin
          if (r_hs) begin
            bcnt   <= bcnt + 9'd1;
            remain <= remain_dec;
            if (bad_beat) err <= 1'b1;
            // Burst boundary is counted locally; RLAST only feeds the error flag.
            if (burst_end) begin
              cur_addr <= addr_inc;
              if (remain_dec == '0) done <= 1'b1;
              else                  blen <= burst_len(addr_inc[11:0], remain_dec);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_testdrive_axi4_read_sequencer.sv
// Scoreboard bench: directed commands push expected AR bursts and beats; a monitor
// pops and compares on every handshake while a simple slave model answers AR.
module tb_testdrive_axi4_read_sequencer;
  localparam int AW = 32, DW = 128, BW = 16, IW = 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [BW-1:0] CMD_BEATS = '0;
  logic          BUSY, DONE, ERR;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARLOCK;
  logic [3:0]    ARCACHE;
  logic [2:0]    ARPROT;
  logic [3:0]    ARREGION;
  logic [3:0]    ARQOS;
  logic          ARVALID;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] DOUT_DATA;
  logic          DOUT_VALID, DOUT_LAST;
  logic          DOUT_READY = 1'b1;

  testdrive_axi4_read_sequencer dut (
    .CLK(CLK), .nRST(nRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_BEATS(CMD_BEATS),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARREGION(ARREGION), .ARQOS(ARQOS),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .DOUT_DATA(DOUT_DATA), .DOUT_VALID(DOUT_VALID), .DOUT_LAST(DOUT_LAST), .DOUT_READY(DOUT_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [127:0] data; logic last;} beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  int    tests = 0, fails = 0;
  int    dout_cnt = 0;
  int    beat_no = 0;
  int    err_beat = 0;
  bit    rand_bp = 1'b0;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_0000, ~a, a + 32'h1234_5678, a};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar.push_back('{addr: a, len: l});
  endtask

  task automatic push_beats(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_beat.push_back('{data: pat(a + 32'(i) * 32'd16), last: (i == n - 1)});
  endtask

  // Downstream ready: always 1, or 50% random when backpressure is enabled.
  initial begin
    forever begin
      @(posedge CLK); #1;
      DOUT_READY = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Slave model: accepts AR with random ARREADY, returns beats addressed by burst offset.
  logic        s_act, ar_fire, r_fire;
  logic [31:0] s_addr, ar_addr_s;
  logic [7:0]  s_len, ar_len_s;
  int          s_k;
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = '0;
    s_act = 1'b0; s_k = 0; s_addr = '0; s_len = '0;
    forever begin
      @(negedge CLK);
      ar_fire   = ARVALID && ARREADY;
      r_fire    = RVALID && RREADY;
      ar_addr_s = ARADDR;
      ar_len_s  = ARLEN;
      @(posedge CLK); #1;
      if (!nRST) begin
        s_act = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end else begin
        if (r_fire) begin
          beat_no++;
          s_k++;
          if (s_k > int'(s_len)) s_act = 1'b0;
        end
        if (ar_fire) begin
          s_act = 1'b1; s_addr = ar_addr_s; s_len = ar_len_s; s_k = 0;
        end
        ARREADY = 1'($urandom_range(0, 1));
        RVALID  = s_act && (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
        RDATA   = s_act ? pat(s_addr + 32'(s_k) * 32'd16) : '0;
        RLAST   = s_act && (s_k == int'(s_len));
        RRESP   = (s_act && (beat_no + 1 == err_beat)) ? 2'b10 : 2'b00;
        RID     = '0;
      end
    end
  end

  // Monitor: handshake scoreboard plus cycle-level timing of DONE/ARVALID/RREADY.
  int    left = 0;
  bit    p_done = 1'b0, p_ar = 1'b0, n_done, n_ar;
  ar_t   a_got;
  beat_t b_got;
  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        left = 0; p_done = 1'b0; p_ar = 1'b0;
      end else begin
        n_done = 1'b0; n_ar = 1'b0;
        if (p_ar) chk("arvalid_timing", ARVALID, 1'b1);
        if (DONE || p_done) chk("done_pulse", DONE, p_done);
        chk("rready_mirror", RREADY, (left > 0) ? DOUT_READY : 1'b0);
        if (left > 0) begin
          chk("dout_valid", DOUT_VALID, RVALID);
          chk("no_ar_in_data", ARVALID, 1'b0);
        end
        if (CMD_VALID && CMD_READY) begin
          if (CMD_BEATS == '0) n_done = 1'b1;
          else                 n_ar = 1'b1;
        end
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) begin
            tests++; fails++;
            $display("FAIL ar_unexpected: got addr %0h len %0d, none required", ARADDR, ARLEN);
          end else begin
            a_got = exp_ar.pop_front();
            chk("araddr", ARADDR, a_got.addr);
            chk("arlen", ARLEN, a_got.len);
            chk("ar_fixed", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARREGION, ARQOS},
                {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0});
            left = int'(ARLEN) + 1;
          end
        end
        if (DOUT_VALID && DOUT_READY) begin
          dout_cnt++;
          if (exp_beat.size() == 0) begin
            tests++; fails++;
            $display("FAIL beat_unexpected: got data %0h, none required", DOUT_DATA);
          end else begin
            b_got = exp_beat.pop_front();
            chk("dout_data", DOUT_DATA, b_got.data);
            chk("dout_last", DOUT_LAST, b_got.last);
            if (left > 0) left--;
            if (b_got.last)     n_done = 1'b1;
            else if (left == 0) n_ar = 1'b1;
          end
        end
        p_done = n_done;
        p_ar   = n_ar;
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
    int t;
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; CMD_ADDR = a; CMD_BEATS = n;
    t = 0;
    @(negedge CLK);
    while (!CMD_READY && t < 2000) begin @(negedge CLK); t++; end
    if (!CMD_READY) begin
      tests++; fails++;
      $display("FAIL cmd_accept: CMD_READY stayed 0, required 1");
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (t < 3000) begin
      @(negedge CLK);
      if (DONE) break;
      t++;
    end
    chk(name, DONE, 1'b1);
    chk({name, "_ready"}, CMD_READY, 1'b1);
    chk({name, "_beats_left"}, 32'(exp_beat.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_ar", {ARADDR, ARLEN}, 40'd0);
    #2 nRST = 1'b1;
    @(negedge CLK);
    chk("idle_cmd_ready", CMD_READY, 1'b1);

    // 40 beats from 0x1000 split at the 16-beat cap
    push_ar(32'h1000, 8'd15); push_ar(32'h1100, 8'd15); push_ar(32'h1200, 8'd7);
    push_beats(32'h1000, 40);
    send_cmd(32'h1000, 16'd40);
    wait_done("done_linear");
    chk("err_linear", ERR, 1'b0);

    // 4 KB page crossing
    push_ar(32'h1FC0, 8'd3); push_ar(32'h2000, 8'd3);
    push_beats(32'h1FC0, 8);
    send_cmd(32'h1FC0, 16'd8);
    wait_done("done_4k");

    // Random backpressure on both sides
    rand_bp = 1'b1;
    push_ar(32'h4000, 8'd15); push_ar(32'h4100, 8'd15); push_ar(32'h4200, 8'd7);
    push_beats(32'h4000, 40);
    send_cmd(32'h4000, 16'd40);
    wait_done("done_backpressure");
    rand_bp = 1'b0;

    // Error response on beat 5
    err_beat = beat_no + 5;
    push_ar(32'h5000, 8'd15); push_ar(32'h5100, 8'd15); push_ar(32'h5200, 8'd7);
    push_beats(32'h5000, 40);
    send_cmd(32'h5000, 16'd40);
    chk("err_before", ERR, 1'b0);
    wait_done("done_err");
    chk("err_sticky", ERR, 1'b1);
    err_beat = 0;

    // Zero-beat command: clears ERR, pulses DONE, no AR
    send_cmd(32'h3000, 16'd0);
    chk("err_cleared", ERR, 1'b0);
    wait_done("done_zero");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("zero_no_ar", ARVALID, 1'b0);
      chk("zero_ready", CMD_READY, 1'b1);
    end

    // Unaligned start address is truncated to the beat boundary
    push_ar(32'h6000, 8'd1);
    push_beats(32'h6000, 2);
    send_cmd(32'h600F, 16'd2);
    wait_done("done_unaligned");

    // Reset in the middle of a data burst
    push_ar(32'h0000, 8'd15);
    push_beats(32'h0000, 40);
    base = dout_cnt;
    send_cmd(32'h0000, 16'd40);
    t = 0;
    while (dout_cnt < base + 10 && t < 3000) begin @(negedge CLK); t++; end
    chk("reach_beat10", 32'(dout_cnt >= base + 10), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_arvalid", ARVALID, 1'b0);
    chk("mid_rst_rready", RREADY, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_done", DONE, 1'b0);
    chk("mid_rst_err", ERR, 1'b0);
    exp_ar.delete();
    exp_beat.delete();
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;

    push_ar(32'h0000, 8'd3);
    push_beats(32'h0000, 4);
    send_cmd(32'h0000, 16'd4);
    wait_done("done_after_rst");
    chk("err_after_rst", ERR, 1'b0);

    repeat (3) @(negedge CLK);
    chk("ar_queue_empty", 32'(exp_ar.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/testdrive_axi4_read_sequencer.md
# testdrive_axi4_read_sequencer

Read-side burst sequencer that sits in front of an AXI4 slave port, typically the DPI-backed AXI4 BFM in the TestDrive system simulation. It accepts one linear read command (start address and beat count) at a time. It splits the command into legal AXI4 INCR bursts that are capped by a maximum length and never cross a 4 KB boundary, issues them one at a time, and forwards read data as a ready/valid stream with end-of-command marking and sticky error status.

## Interface
Parameters:
- C_THREAD_ID_WIDTH, 1: ARID/RID width
- C_ADDR_WIDTH, 32: address width
- C_DATA_WIDTH, 128: data width; power of two, 8..1024; BPB = C_DATA_WIDTH/8 bytes per beat
- C_ARID, 0: constant ARID driven and expected on RID
- C_MAX_BURST, 16: maximum beats per burst, 1..256
- C_BEATS_WIDTH, 16: width of the command beat count

Ports:
- CLK  in  1  clock; everything is sampled on its rising edge
- nRST  in  1  reset, asynchronous assert, active low
- CMD_VALID  in  1  command valid
- CMD_READY  out  1  command ready; high only in IDLE
- CMD_ADDR  in  C_ADDR_WIDTH  start byte address; low log2(BPB) bits are forced to 0
- CMD_BEATS  in  C_BEATS_WIDTH  number of beats to read
- BUSY  out  1  high while the state is not IDLE
- DONE  out  1  one-cycle pulse when a command completes
- ERR  out  1  sticky error; cleared when the next command is accepted
- ARID  out  C_THREAD_ID_WIDTH  fixed at C_ARID
- ARADDR  out  C_ADDR_WIDTH  burst start address
- ARLEN  out  8  burst length minus 1
- ARSIZE  out  3  fixed at log2(BPB)
- ARBURST  out  2  fixed at 2'b01 (INCR)
- ARLOCK/ARCACHE/ARPROT/ARREGION/ARQOS  out  1/4/3/4/4  fixed at 0 / 4'b0011 / 0 / 0 / 0
- ARVALID  out  1  address valid
- ARREADY  in  1  address ready
- RID  in  C_THREAD_ID_WIDTH  read ID
- RDATA  in  C_DATA_WIDTH  read data
- RRESP  in  2  read response
- RLAST  in  1  last beat of the burst
- RVALID  in  1  read valid
- RREADY  out  1  combinational copy of DOUT_READY while in DATA, otherwise 0
- DOUT_DATA  out  C_DATA_WIDTH  combinational copy of RDATA
- DOUT_VALID  out  1  RVALID gated by state DATA
- DOUT_LAST  out  1  final beat of the whole command
- DOUT_READY  in  1  downstream ready

## Operation
- States: IDLE, ADDR, DATA.
- Registers:
  - cur_addr (C_ADDR_WIDTH)
  - remain (C_BEATS_WIDTH)
  - blen (9 bits, 1..256)
  - bcnt (9 bits)
- Next burst length: blen_next = min(remain, C_MAX_BURST, (4096 - cur_addr[11:0]) / BPB). This is computed combinationally from the registers and captured on every entry to ADDR.
- IDLE, on CMD_VALID & CMD_READY:
  - cur_addr <= aligned CMD_ADDR; remain <= CMD_BEATS; ERR <= 0.
  - If CMD_BEATS == 0: stay in IDLE and pulse DONE next cycle. No AR traffic is issued.
  - Otherwise: go to ADDR.
- ADDR:
  - ARVALID = 1, ARADDR = cur_addr, ARLEN = blen - 1.
  - All AR outputs are held stable until ARREADY is sampled high; then go to DATA with bcnt = 0.
- DATA: each R handshake (RVALID & RREADY) does the following:
  - bcnt++ and remain--.
  - ERR <= 1 if RRESP != 0, or if RID != C_ARID, or if RLAST != (bcnt == blen - 1).
  - Beats are always forwarded, including error beats.
- DOUT_LAST = DOUT_VALID & (remain == 1).
- Burst end is decided by bcnt, not by RLAST. When bcnt reaches blen:
  - cur_addr += blen*BPB, modulo 2^C_ADDR_WIDTH.
  - Go to ADDR if remain != 0; otherwise go to IDLE and pulse DONE.
- Only one burst is outstanding at a time. AR is never reissued before the previous burst's last beat.
- Unexpected RVALID while not in DATA is not accepted, because RREADY = 0.

## Timing
- Reset values: state IDLE, ARVALID 0, BUSY 0, DONE 0, ERR 0, all AR fields at their constant or zero values, cur_addr 0, remain 0. With nRST high, CMD_READY = 1 in IDLE from the first cycle.
- Command accepted in cycle N: ARVALID is high in cycle N+1.
- AR handshake in cycle A: RREADY can go high in cycle A+1.
- Last beat of a burst in cycle M:
  - The next burst's ARVALID is high in M+1, or
  - DONE and CMD_READY are high together in M+1, and a new command may be accepted in M+1.
- RREADY/DOUT_VALID have a zero-cycle combinational path; there is no buffering and no beat loss under backpressure.
- Reset asserted mid-operation: immediate return to the reset state, and the current command is abandoned. The slave side must be reset together with this block.

## Test plan
- C_DATA_WIDTH=128, C_MAX_BURST=16, CMD 0x1000/40 beats -> AR bursts 0x1000 len 15, 0x1100 len 15, 0x1200 len 7; 40 DOUT beats in order; DOUT_LAST on beat 40; DONE one cycle later; ERR 0.
- 4 KB crossing, CMD 0x1FC0/8 -> ARADDR 0x1FC0 ARLEN 3, then 0x2000 ARLEN 3.
- DOUT_READY toggled randomly at 50% over 40 beats -> RREADY mirrors DOUT_READY every cycle; all 40 beats delivered in order with none duplicated.
- RRESP=2'b10 on beat 5 of 40 -> ERR rises after beat 5; all 40 beats still delivered; ERR returns to 0 when the next command is accepted.
- CMD_BEATS=0 -> DONE pulses in the next cycle, ARVALID never rises, CMD_READY stays 1.
- nRST asserted during DATA (beat 10 of 40) -> ARVALID/RREADY/BUSY/DONE/ERR are 0 immediately; after release a new CMD 0x0/4 completes with ARLEN 3.
